bin_log_scaler: RTL

//  Sits between the sliding DFT readout and the frequency-bin BRAM, on the pixel clock.

---
 rtl/bin_log_scaler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bin_log_scaler.sv
// Bin magnitude to 8-bit pseudo-log with noise floor, shift gain and saturation; 3-cycle pipeline.
// Optional per-bin peak-hold with linear decay: define BIN_LOG_SCALER_PEAK_HOLD_EN.
module bin_log_scaler #(
    parameter int         FREQ_BINS  = 320,
    parameter int         ADDR_W     = 9,
    parameter int         BIN_W      = 16,
    parameter logic [7:0] FLOOR      = 8'h40,
    parameter int         GAIN_SHIFT = 1,
    parameter int         DECAY      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BIN_W-1:0]  in_bin,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_last,
    output logic              busy,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic [ADDR_W-1:0] frame_clips
);

    typedef enum logic {CLEAR, RUN} state_t;

`ifdef BIN_LOG_SCALER_PEAK_HOLD_EN
    localparam logic [ADDR_W:0] N_BINS  = (ADDR_W+1)'(FREQ_BINS);
    localparam logic [7:0]      DECAY_L = 8'(DECAY);
    localparam logic [ADDR_W:0] CLR_END = N_BINS;
`else
    localparam logic [ADDR_W:0] CLR_END = '0;
`endif

    // Leading-one exponent with the next four bits as mantissa, zero-padded on the right.
    function automatic logic [7:0] pseudo_log(input logic [15:0] x);
        logic [3:0]  p;
        logic [15:0] sh;
        p = 4'd0;
        for (int i = 0; i < 16; i++)
            if (x[i]) p = 4'(i);
        sh = x << (4'd15 - p);
        return {p, sh[14:11]};
    endfunction

    // Returns {clip, s}: floor subtract clamped at zero, shift gain, saturate to 8 bits.
    function automatic logic [8:0] scale_sat(input logic [7:0] lg);
        logic signed [8:0] d;
        logic [10:0]       s;
        d = $signed({1'b0, lg}) - $signed({1'b0, FLOOR});
        if (d < 0) d = '0;
        s = {3'b000, d[7:0]} << GAIN_SHIFT;
        if (s > 11'd255) return {1'b1, 8'hFF};
        else             return {1'b0, s[7:0]};
    endfunction

`ifdef BIN_LOG_SCALER_PEAK_HOLD_EN
    function automatic logic [7:0] decay_peak(input logic [7:0] p);
        return (p > DECAY_L) ? p - DECAY_L : 8'h00;
    endfunction
`endif

    state_t            state, state_nx;
    logic [ADDR_W:0]   clr_cnt, clr_cnt_nx;
    logic              accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        busy       = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr_cnt == CLR_END) state_nx   = RUN;
                else                    clr_cnt_nx = clr_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = in_valid & ~busy;

    // Stage 1: pseudo-log
    logic              vld_p0, last_p0;
    logic [7:0]        log_p0;
    logic [ADDR_W-1:0] addr_p0;

    always_ff @(posedge clk) begin
        if (reset) vld_p0 <= 1'b0;
        else       vld_p0 <= accept;
        if (accept) begin
            log_p0  <= pseudo_log(in_bin);
            addr_p0 <= in_addr;
            last_p0 <= in_last;
        end
    end

    // Stage 2: floor, gain, saturation; peak read issued here
    logic              vld_p1, last_p1, clip_p1;
    logic [7:0]        s_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [8:0]        scaled;
    logic [7:0]        out_s3;

    assign scaled = scale_sat(log_p0);

    always_ff @(posedge clk) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= vld_p0;
        if (vld_p0) begin
            s_p1    <= scaled[7:0];
            clip_p1 <= scaled[8];
            addr_p1 <= addr_p0;
            last_p1 <= last_p0;
        end
    end

`ifdef BIN_LOG_SCALER_PEAK_HOLD_EN
    logic [7:0] peak_ram [FREQ_BINS];
    logic [7:0] pk_p1, q_s3;
    logic       rng_p0, rng_p1, fwd;

    assign rng_p0 = {1'b0, addr_p0} < N_BINS;
    // The bin in stage 3 writes on the same edge this read samples, so bypass it.
    assign fwd    = vld_p1 & rng_p1 & (addr_p1 == addr_p0);

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            rng_p1 <= rng_p0;
            if (fwd)         pk_p1 <= out_s3;
            else if (rng_p0) pk_p1 <= peak_ram[addr_p0];
            else             pk_p1 <= 8'h00;
        end
        if (state == CLEAR && clr_cnt < N_BINS)
            peak_ram[clr_cnt[ADDR_W-1:0]] <= 8'h00;
        else if (vld_p1 && rng_p1)
            peak_ram[addr_p1] <= out_s3;
    end

    assign q_s3   = decay_peak(pk_p1);
    assign out_s3 = (rng_p1 && q_s3 > s_p1) ? q_s3 : s_p1;
`else
    assign out_s3 = s_p1;
`endif

    // Stage 3: output register, peak write-back and clip accounting
    logic [ADDR_W-1:0] clip_cnt, clip_inc;

    assign clip_inc = (clip_p1 && clip_cnt != '1) ? clip_cnt + 1'b1 : clip_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_addr    <= '0;
            out_data    <= 8'h00;
            frame_clips <= '0;
            clip_cnt    <= '0;
        end else begin
            out_valid <= vld_p1;
            out_last  <= vld_p1 & last_p1;
            if (vld_p1) begin
                out_addr <= addr_p1;
                out_data <= out_s3;
                if (last_p1) begin
                    frame_clips <= clip_inc;
                    clip_cnt    <= '0;
                end else begin
                    clip_cnt    <= clip_inc;
                end
            end
        end
    end

endmodule
